// File: rtl/div_pkg.sv
// Purpose : shared constants and state type for the sequential divider.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    localparam int DIV_WIDTH = 32;  // operand / quotient / remainder width
    localparam int DIV_ITER  = 32;  // one quotient bit retired per RUN cycle
    localparam int DIV_CNT_W = 6;   // iteration counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/sub_borrow33.sv
// Purpose : 33-bit trial subtract A - B, done as A + ~B + 1.
// Latency : combinational.
// Backpressure: none.
// Ports   : i_a, i_b (33-bit operands); o_diff (low 32 bits of A - B);
//           o_borrow (bit 32 of the 33-bit difference, 1 when A < B).
module sub_borrow33 (
    input  logic [32:0] i_a,
    input  logic [32:0] i_b,
    output logic [31:0] o_diff,
    output logic        o_borrow
);

    logic [32:0] w_t;

    // Inverse of the carry-in adder: add the one's complement with carry-in 1.
    // Bit 32 of the result is the borrow as long as |A - B| < 2^32, which the
    // divider guarantees because its partial remainder is always below D.
    assign w_t      = i_a + ~i_b + 33'd1;
    assign o_diff   = w_t[31:0];
    assign o_borrow = w_t[32];

endmodule

// File: rtl/div32_seq.sv
// Purpose : iterative restoring divider, one quotient bit per clock.
// Latency : 33 cycles start-to-done; 1 cycle for divide by zero.
// Backpressure: none; start is only sampled in IDLE, anything else is dropped.
// Ports   : clk, rst_n (async active-low); start + dividend/divisor request;
//           busy while iterating; done one-cycle result pulse; quotient,
//           remainder, div_zero held until the next accepted start.
// Option  : define DIV32_SIGNED_EN to add the sign input and signed division.
module div32_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV32_SIGNED_EN
    input  logic             sign,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    div_state_t             r_state;
    div_state_t             w_state_nxt;
    logic [WIDTH-1:0]       r_rem;   // partial remainder (top bit of the 33-bit R is always 0)
    logic [WIDTH-1:0]       r_q;     // dividend shifts out, quotient bits shift in
    logic [WIDTH-1:0]       r_d;
    logic [DIV_CNT_W-1:0]   r_cnt;

    logic                   w_accept;
    logic                   w_div0;
    logic                   w_last;
    logic [WIDTH:0]         w_trial;
    logic [WIDTH-1:0]       w_diff;
    logic                   w_borrow;
    logic [WIDTH-1:0]       w_rem_nxt;
    logic [WIDTH-1:0]       w_q_nxt;
    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic [WIDTH-1:0]       w_q_res;
    logic [WIDTH-1:0]       w_r_res;

    assign w_accept = (r_state == IDLE) && start;
    assign w_div0   = (divisor == '0);
    assign w_last   = (r_cnt == DIV_CNT_W'(DIV_ITER - 1));

    // Shift the next dividend bit into the partial remainder and try D.
    assign w_trial = {r_rem, r_q[WIDTH-1]};

    sub_borrow33 u_sub (
        .i_a      (w_trial),
        .i_b      ({1'b0, r_d}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // Restore on borrow by keeping the shifted value instead of the difference.
    assign w_rem_nxt = w_borrow ? w_trial[WIDTH-1:0] : w_diff;
    assign w_q_nxt   = {r_q[WIDTH-2:0], ~w_borrow};

`ifdef DIV32_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    // -2^31 maps to 0x80000000, which is the right unsigned magnitude.
    assign w_a_mag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_b_mag = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign w_q_res = r_neg_q ? -w_q_nxt   : w_q_nxt;
    assign w_r_res = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r <= sign && dividend[WIDTH-1];
        end
    end
`else
    assign w_a_mag = dividend;
    assign w_b_mag = divisor;
    assign w_q_res = w_q_nxt;
    assign w_r_res = w_rem_nxt;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_div0 ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath and result registers. Results are written only on the final
    // iteration (or immediately for divide by zero), so no partial value is
    // ever visible on quotient/remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem     <= '0;
            r_q       <= '0;
            r_d       <= '0;
            r_cnt     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (w_accept) begin
            r_rem <= '0;
            r_q   <= w_a_mag;
            r_d   <= w_b_mag;
            r_cnt <= '0;
            if (w_div0) begin
                quotient  <= '1;
                remainder <= dividend;
                div_zero  <= 1'b1;
            end else begin
                div_zero  <= 1'b0;
            end
        end else if (r_state == RUN) begin
            r_rem <= w_rem_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + DIV_CNT_W'(1);
            if (w_last) begin
                quotient  <= w_q_res;
                remainder <= w_r_res;
            end
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Purpose : self-checking bench for div32_seq (vector table, corner sequences, random vs model).
// Latency : checks 33-cycle normal and 1-cycle divide-by-zero completion.
// Backpressure: checks that start outside IDLE is dropped.
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        tb_sign;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div32_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
`ifdef DIV32_SIGNED_EN
        .sign      (tb_sign),
`endif
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain integer division semantics.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else if (s) begin
            dz = 1'b0;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
    endtask

    // Issue one request and follow it to done. inj > 0 pulses a competing
    // 50/5 start at that cycle count, which must be ignored.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int inj,
                         output int lat, output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic busy_bad, output logic dz_first);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        lat = 1; busy_bad = 1'b0; dz_first = div_zero;
        while (!done && lat < 100) begin
            if (busy !== (b != 32'd0)) busy_bad = 1'b1;
            if (lat == inj) begin
                start = 1'b1; dividend = 32'd50; divisor = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (busy) busy_bad = 1'b1;
        q = quotient; r = remainder; dz = div_zero;
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b, input int inj,
                           input logic [31:0] eq, input logic [31:0] er, input logic edz);
        int          lat;
        logic [31:0] q, r;
        logic        dz, busy_bad, dz_first;
        do_op(a, b, inj, lat, q, r, dz, busy_bad, dz_first);
        chk({tag, " latency"}, 32'(lat), (b == 32'd0) ? 32'd1 : 32'd33);
        chk({tag, " quotient"}, q, eq);
        chk({tag, " remainder"}, r, er);
        chk({tag, " div_zero"}, {31'd0, dz}, {31'd0, edz});
        chk({tag, " busy"}, {31'd0, busy_bad}, 32'd0);
        if (b != 32'd0) chk({tag, " div_zero cleared"}, {31'd0, dz_first}, 32'd0);
    endtask

    task automatic run_rand(input string tag, input int n);
        logic [31:0] a, b, eq, er;
        logic        edz;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) b = 32'd0;
            model(a, b, tb_sign, eq, er, edz);
            run_vec($sformatf("%s%0d", tag, i), a, b, 0, eq, er, edz);
        end
    endtask

    vec_t tv[8];

    initial begin
        tv[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,  dz: 1'b0};
        tv[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,  dz: 1'b0};
        tv[2] = '{a: 32'd5,          b: 32'hFFFF_FFFF,  q: 32'd0,          r: 32'd5,  dz: 1'b0};
        tv[3] = '{a: 32'd5,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd5,  dz: 1'b1};
        tv[4] = '{a: 32'd0,          b: 32'd3,          q: 32'd0,          r: 32'd0,  dz: 1'b0};
        tv[5] = '{a: 32'h8000_0000,  b: 32'd2,          q: 32'h4000_0000,  r: 32'd0,  dz: 1'b0};
        tv[6] = '{a: 32'd7,          b: 32'd7,          q: 32'd1,          r: 32'd0,  dz: 1'b0};
        tv[7] = '{a: 32'hFFFF_FFFF,  b: 32'h0001_0000,  q: 32'h0000_FFFF,  r: 32'h0000_FFFF, dz: 1'b0};

        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0; tb_sign = 1'b0;
        #23;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_vec($sformatf("vec%0d", i), tv[i].a, tv[i].b, 0, tv[i].q, tv[i].r, tv[i].dz);

        // Results hold through IDLE.
        run_vec("hold op", 32'd100, 32'd7, 0, 32'd14, 32'd2, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold quotient", quotient, 32'd14);
        chk("hold remainder", remainder, 32'd2);
        chk("hold done low", {31'd0, done}, 32'd0);

        // A start pulse mid-RUN is dropped.
        run_vec("ignored start", 32'd9, 32'd3, 10, 32'd3, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        chk("ignored start no restart", {31'd0, busy}, 32'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("midrun busy before reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun reset busy", {31'd0, busy}, 32'd0);
        chk("midrun reset done", {31'd0, done}, 32'd0);
        chk("midrun reset quotient", quotient, 32'd0);
        chk("midrun reset remainder", remainder, 32'd0);
        chk("midrun reset div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("after reset", 32'd20, 32'd6, 0, 32'd3, 32'd2, 1'b0);

        run_rand("rand_u", 30);

`ifdef DIV32_SIGNED_EN
        tb_sign = 1'b1;
        run_vec("s -7/2", 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_vec("s min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 32'd0, 1'b0);
        run_vec("s 7/-2", 32'd7, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_vec("s -8/-3", 32'hFFFF_FFF8, 32'hFFFF_FFFD, 0, 32'd2, 32'hFFFF_FFFE, 1'b0);
        run_vec("s -8/0", 32'hFFFF_FFF8, 32'd0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1);
        run_rand("rand_s", 30);
        tb_sign = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
